lsdbuf_readout_ctrl: RTL
========================

// Module: lsdbuf_readout_ctrl
// PURPOSE
//  Sequences a software-triggered readout of the LSD line-segment buffer in image_processor.
//  Locks the buffer with write_protect and waits for ready.
//  Walks raddr over 0..line_num-1 and streams each segment's coordinates as valid/ready beats.
//  The zynq_ps_interface side consumes these beats, then the block releases the lock.
//  Sits on ps_clk between zynq_ps_interface registers and image_processor LSD buffer ports.
// PARAMETERS
//  H_FRAME        800   horizontal frame size; HW = $clog2(H_FRAME)
//  V_FRAME        525   vertical frame size;   VW = $clog2(V_FRAME)
//  LSD_BUFSIZE    4096  buffer entries; AW = $clog2(LSD_BUFSIZE)
//  RD_LATENCY     2     cycles from raddr change to valid coordinate outputs (>=1)
//  READY_TIMEOUT  65535 max cycles in WAIT_RDY before abort (>=1)
// PORTS
//  clk                      in   1         ps_clk domain clock
//  rst                      in   1         synchronous, active-high reset
//  start                    in   1         1-cycle request from PS register; ignored unless IDLE
//  abort                    in   1         terminate readout, go to RELEASE
//  out_lsdbuf_write_protect out  1         freezes buffer contents while high
//  out_lsdbuf_raddr         out  AW        buffer read address
//  in_lsdbuf_ready          in   1         buffer stable under protect
//  in_lsdbuf_line_num       in   AW        valid entries in buffer
//  in_lsdbuf_start_v/_h     in   VW/HW     segment start point at raddr
//  in_lsdbuf_end_v/_h       in   VW/HW     segment end point at raddr
//  m_valid                  out  1         beat valid
//  m_ready                  in   1         consumer accepts beat
//  m_data                   out  2*(VW+HW) {start_v,start_h,end_v,end_h}
//  m_last                   out  1         high with final beat
//  busy                     out  1         state != IDLE
//  done                     out  1         1-cycle pulse on leaving RELEASE
//  lines_read               out  AW+1      beats accepted in current/last readout
//  err_timeout / err_clamp  out  1 each    sticky; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; m_data 0.
//   rst mid-readout drops write_protect on the next edge, with no done pulse.
//  States: IDLE, WAIT_RDY, WAIT_DATA, SEND, RELEASE.
//  IDLE: on start -> WAIT_RDY.
//   Same edge: write_protect<=1, raddr<=0, lines_read<=0, clear err_*, timer<=0.
//  WAIT_RDY: on in_lsdbuf_ready -> latch total = min(line_num, LSD_BUFSIZE).
//   Set err_clamp if clamped (unreachable when LSD_BUFSIZE is a power of 2).
//   If total==0 -> RELEASE, no beats. Else -> WAIT_DATA with lat_cnt<=0.
//   Timer reaching READY_TIMEOUT -> err_timeout<=1 -> RELEASE.
//  WAIT_DATA: lat_cnt counts to RD_LATENCY-1.
//   Then capture coordinates into m_data and set m_valid<=1 -> SEND.
//   m_last<=(raddr==total-1).
//  SEND: m_valid and m_data held stable until m_ready (AXIS rules; m_valid never drops unaccepted).
//   On accept: lines_read++. m_valid<=0.
//   If m_last -> RELEASE; else raddr++ -> WAIT_DATA.
//   Throughput: one beat per RD_LATENCY+1 cycles when m_ready is held high.
//  RELEASE: write_protect<=0, done<=1 (one cycle), m_last<=0 -> IDLE.
//   So write_protect falls exactly one edge after the last accept.
//  abort in WAIT_RDY/WAIT_DATA/SEND -> RELEASE next edge; an unaccepted beat is dropped.
//   abort and m_ready in the same cycle: accept counts, then RELEASE.
//   abort in IDLE/RELEASE ignored. start while busy ignored.
//  raddr never exceeds total-1. lines_read saturates at total.
// STRUCTURE
//  lsd_pkg: state enum lsdrd_state_t, width localparams HW/VW/AW, seg_t packed struct.
//   seg_t is shared with image_processor's LSD buffer.
//  Single module; no sub-module. The timer and lat_cnt are local counters.
// TESTING
//  1 line_num=3, m_ready=1, RD_LATENCY=2: 3 beats, 3 cycles apart, raddr 0,1,2.
//    m_last on the 3rd beat; done 1 cycle after; lines_read=3.
//  2 line_num=0: write_protect high then low; zero beats; done pulses; lines_read=0.
//  3 ready held low, READY_TIMEOUT=16: err_timeout=1 after 16 cycles; protect drops; done.
//  4 m_ready random 30%: m_data stable while m_valid&&!m_ready.
//    All 5 segments match the model in order.
//  5 abort in SEND at beat 2 of 5: no further beats; protect low next edge; lines_read=1.
//  6 rst asserted in WAIT_DATA: every output 0 next edge. start 1 cycle later: readout from raddr 0.

Source files
------------

// File: rtl/lsd_pkg.sv
// lsd_pkg: shared LSD buffer widths, segment record and readout state encoding
package lsd_pkg;
  localparam int HW = $clog2(800);
  localparam int VW = $clog2(525);
  localparam int AW = $clog2(4096);
  typedef struct packed {
    logic [VW-1:0] start_v;
    logic [HW-1:0] start_h;
    logic [VW-1:0] end_v;
    logic [HW-1:0] end_h;
  } seg_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WAIT_DATA,
    S_SEND,
    S_RELEASE
  } lsdrd_state_t;
endpackage

// File: rtl/lsdbuf_readout_ctrl.sv
// lsdbuf_readout_ctrl: locks the LSD buffer and streams its segments as valid/ready beats
module lsdbuf_readout_ctrl #(
  parameter int H_FRAME = 800,
  parameter int V_FRAME = 525,
  parameter int LSD_BUFSIZE = 4096,
  parameter int RD_LATENCY = 2,
  parameter int READY_TIMEOUT = 65535,
  localparam int HW = $clog2(H_FRAME),
  localparam int VW = $clog2(V_FRAME),
  localparam int AW = $clog2(LSD_BUFSIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   out_lsdbuf_write_protect,
  output logic [AW-1:0]          out_lsdbuf_raddr,
  input  logic                   in_lsdbuf_ready,
  input  logic [AW-1:0]          in_lsdbuf_line_num,
  input  logic [VW-1:0]          in_lsdbuf_start_v,
  input  logic [HW-1:0]          in_lsdbuf_start_h,
  input  logic [VW-1:0]          in_lsdbuf_end_v,
  input  logic [HW-1:0]          in_lsdbuf_end_h,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*(VW+HW)-1:0]   m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done,
  output logic [AW:0]            lines_read,
  output logic                   err_timeout,
  output logic                   err_clamp
);
  import lsd_pkg::*;
  localparam int LW = $clog2(RD_LATENCY + 1);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [AW:0] CAP = (AW+1)'(LSD_BUFSIZE);
  lsdrd_state_t r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [LW-1:0] r_lat;
  logic [AW:0] r_total, w_total, r_lines;
  logic [AW-1:0] r_raddr;
  logic [2*(VW+HW)-1:0] r_data;
  logic r_wp, r_valid, r_last, r_done, r_err_timeout, r_err_clamp;
  logic w_clamp, w_lat_done, w_timeout, w_accept;
  assign out_lsdbuf_write_protect = r_wp;
  assign out_lsdbuf_raddr = r_raddr;
  assign m_valid = r_valid;
  assign m_data = r_data;
  assign m_last = r_last;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign lines_read = r_lines;
  assign err_timeout = r_err_timeout;
  assign err_clamp = r_err_clamp;
  always_comb begin
    w_clamp = {1'b0, in_lsdbuf_line_num} > CAP;
    w_total = w_clamp ? CAP : {1'b0, in_lsdbuf_line_num};
    w_lat_done = r_lat == LW'(RD_LATENCY - 1);
    w_timeout = r_timer == TW'(READY_TIMEOUT - 1);
    w_accept = r_valid && m_ready;
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = start ? S_WAIT_RDY : S_IDLE;
      S_WAIT_RDY:  w_next = abort ? S_RELEASE :
                            in_lsdbuf_ready ? (w_total == '0 ? S_RELEASE : S_WAIT_DATA) :
                            w_timeout ? S_RELEASE : S_WAIT_RDY;
      S_WAIT_DATA: w_next = abort ? S_RELEASE : w_lat_done ? S_SEND : S_WAIT_DATA;
      S_SEND:      w_next = (abort || (w_accept && r_last)) ? S_RELEASE :
                            w_accept ? S_WAIT_DATA : S_SEND;
      S_RELEASE:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= 1'b0;
      r_raddr <= '0;
      r_lines <= '0;
      r_total <= '0;
      r_timer <= '0;
      r_lat <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_clamp <= 1'b0;
    end else begin
      r_done <= r_state == S_RELEASE;
      case (r_state)
        S_IDLE: if (start) begin
          r_wp <= 1'b1;
          r_raddr <= '0;
          r_lines <= '0;
          r_err_timeout <= 1'b0;
          r_err_clamp <= 1'b0;
          r_timer <= '0;
        end
        S_WAIT_RDY: begin
          r_timer <= r_timer + 1'b1;
          if (!abort && in_lsdbuf_ready) begin
            r_total <= w_total;
            r_err_clamp <= w_clamp;
            r_lat <= '0;
          end else if (!abort && w_timeout) r_err_timeout <= 1'b1;
        end
        S_WAIT_DATA: begin
          r_lat <= r_lat + 1'b1;
          if (!abort && w_lat_done) begin
            r_data <= {in_lsdbuf_start_v, in_lsdbuf_start_h, in_lsdbuf_end_v, in_lsdbuf_end_h};
            r_valid <= 1'b1;
            r_last <= {1'b0, r_raddr} == r_total - 1'b1;
          end
        end
        S_SEND: begin
          // an accept in the abort cycle still counts; an unaccepted beat is dropped
          if (w_accept) r_lines <= (r_lines == r_total) ? r_lines : r_lines + 1'b1;
          if (w_accept || abort) r_valid <= 1'b0;
          if (w_accept && !r_last && !abort) begin
            r_raddr <= r_raddr + 1'b1;
            r_lat <= '0;
          end
        end
        S_RELEASE: begin
          r_wp <= 1'b0;
          r_last <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
